debounce_sync: RTL and testbench

- Cleans a raw, asynchronous, bouncing single-bit input (push-button or switch) into a glitch-free synchronous level, plus one-cycle edge pulses.
- Sits directly upstream of the single-bit inverter gate: its `y` output drives that gate's input `a`.
- Combines a two-flop synchronizer with a stability counter and a 4-state FSM.

---
 rtl/debounce_sync_pkg.sv | 5 +
 rtl/debounce_sync_sync2.sv | 19 +
 rtl/debounce_sync.sv | 116 +++++++++++
 tb/tb_debounce_sync.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/debounce_sync_pkg.sv
// Shared types and defaults for the push-button / switch debouncer.
package debounce_pkg;
  typedef enum logic [1:0] {IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO} db_state_t;
  localparam int DB_DEFAULT_CYCLES = 4;
endpackage

// File: rtl/debounce_sync_sync2.sv
// Two-flop synchronizer bringing an asynchronous bit into the clk domain.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      q    <= 1'b0;
    end else begin
      s1_q <= d;
      q    <= s1_q;
    end
  end
endmodule

// File: rtl/debounce_sync.sv
// Debouncer: synchronizer, stability counter and 4-state FSM producing a clean
// level plus one-cycle rise/fall pulses.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DB_DEFAULT_CYCLES,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic a_in,
  output logic y,
  output logic rise,
  output logic fall,
  output logic busy
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s;
  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             y_d, rise_d, fall_d;

  sync2 u_sync2 (
    .clk (clk),
    .rst (rst),
    .d   (a_in),
    .q   (s)
  );

  // Counter holds the number of consecutive samples that disagreed with y.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      IDLE_LO: begin
        cnt_d = '0;
        if (s) begin
          if (STABLE_CYCLES == 1) begin
            state_d = IDLE_HI;
            y_d     = 1'b1;
            rise_d  = 1'b1;
          end else begin
            state_d = WAIT_HI;
            cnt_d   = CNT_ONE;
          end
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HI;
          y_d     = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HI: begin
        cnt_d = '0;
        if (!s) begin
          if (STABLE_CYCLES == 1) begin
            state_d = IDLE_LO;
            y_d     = 1'b0;
            fall_d  = 1'b1;
          end else begin
            state_d = WAIT_LO;
            cnt_d   = CNT_ONE;
          end
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LO;
          y_d     = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      y       <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y       <= y_d;
      rise    <= rise_d;
      fall    <= fall_d;
    end
  end

  assign busy = (state_q == WAIT_HI) || (state_q == WAIT_LO);
endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync at STABLE_CYCLES=4 and =1, each feeding an inverter.
module tb_debounce_sync;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] a_in = 2'b00;
  logic [1:0] y, rise, fall, busy, inv;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  debounce_sync #(.STABLE_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .a_in(a_in[0]),
    .y(y[0]), .rise(rise[0]), .fall(fall[0]), .busy(busy[0])
  );

  debounce_sync #(.STABLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .a_in(a_in[1]),
    .y(y[1]), .rise(rise[1]), .fall(fall[1]), .busy(busy[1])
  );

  // Downstream single-bit inverter gates driven by y.
  assign inv = ~y;

  // Model: y flips once the synchronized input has disagreed with y for N
  // consecutive sampled edges; busy while a partial run is in progress.
  logic [1:0] m_s1 = '0, m_s = '0, m_y = '0, m_rise = '0, m_fall = '0;
  int         m_run [2] = '{0, 0};
  bit         seen_edge = 1'b0;

  function automatic int n_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  always @(posedge clk) begin
    cyc++;
    seen_edge = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_s1[i] = 1'b0; m_s[i] = 1'b0; m_y[i] = 1'b0;
        m_rise[i] = 1'b0; m_fall[i] = 1'b0; m_run[i] = 0;
      end else begin
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
        if (m_s[i] != m_y[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == n_of(i)) begin
            m_y[i]    = m_s[i];
            m_rise[i] = m_s[i];
            m_fall[i] = ~m_s[i];
            m_run[i]  = 0;
          end
        end else begin
          m_run[i] = 0;
        end
        m_s[i]  = m_s1[i];
        m_s1[i] = a_in[i];
      end
    end
  end

  always @(negedge clk) begin
    if (seen_edge) begin
      for (int i = 0; i < 2; i++) begin
        logic [4:0] act, exp;
        act = {y[i], rise[i], fall[i], busy[i], inv[i]};
        exp = {m_y[i], m_rise[i], m_fall[i], (m_run[i] != 0), ~m_y[i]};
        n_vec++;
        if (act !== exp) begin
          n_err++;
          $display("FAIL cycle%0d model_inst%0d {y,rise,fall,busy,inv} got=%b want=%b",
                   cyc, i, act, exp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle%0d got=%b want=%b", nm, cyc, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; a_in = 2'b00;
    tick(3);
    chk("reset_y4", y[0], 1'b0);
    chk("reset_rise4", rise[0], 1'b0);
    chk("reset_busy4", busy[0], 1'b0);
    chk("reset_y1", y[1], 1'b0);
    chk("reset_inv4", inv[0], 1'b1);

    // Clean press, N=4: a set before edge k, y rises at edge k+5.
    rst = 1'b0; a_in[0] = 1'b1;
    tick(5);
    chk("press_y_early", y[0], 1'b0);
    chk("press_busy", busy[0], 1'b1);
    tick(1);
    chk("press_y", y[0], 1'b1);
    chk("press_rise", rise[0], 1'b1);
    chk("press_busy_done", busy[0], 1'b0);
    tick(1);
    chk("press_rise_1cyc", rise[0], 1'b0);

    // Release mirror.
    a_in[0] = 1'b0;
    tick(5);
    chk("rel_y_early", y[0], 1'b1);
    chk("rel_fall_early", fall[0], 1'b0);
    tick(1);
    chk("rel_y", y[0], 1'b0);
    chk("rel_fall", fall[0], 1'b1);
    chk("rel_rise", rise[0], 1'b0);
    tick(1);
    chk("rel_fall_1cyc", fall[0], 1'b0);

    // Bounce 1,0,1,0 then held high.
    a_in[0] = 1'b1; tick(1);
    a_in[0] = 1'b0; tick(1);
    a_in[0] = 1'b1; tick(1);
    a_in[0] = 1'b0; tick(1);
    a_in[0] = 1'b1;
    tick(5);
    chk("bounce_y_early", y[0], 1'b0);
    tick(1);
    chk("bounce_y", y[0], 1'b1);
    chk("bounce_rise", rise[0], 1'b1);
    tick(2);

    // Reset while high: y clears, no fall pulse.
    rst = 1'b1;
    tick(1);
    chk("rsthi_y", y[0], 1'b0);
    chk("rsthi_fall", fall[0], 1'b0);
    chk("rsthi_busy", busy[0], 1'b0);

    // Reset in WAIT_HI with cnt=2, then a held high produces a normal rise.
    rst = 1'b0;
    tick(3);
    chk("wait_busy", busy[0], 1'b1);
    tick(1);
    rst = 1'b1;
    tick(1);
    chk("rstwait_busy", busy[0], 1'b0);
    chk("rstwait_y", y[0], 1'b0);
    chk("rstwait_rise", rise[0], 1'b0);
    rst = 1'b0;
    tick(5);
    chk("post_rst_y_early", y[0], 1'b0);
    tick(1);
    chk("post_rst_y", y[0], 1'b1);
    chk("post_rst_rise", rise[0], 1'b1);

    // N=1: output updates at edge k+2.
    a_in[1] = 1'b1;
    tick(2);
    chk("n1_y_early", y[1], 1'b0);
    tick(1);
    chk("n1_y", y[1], 1'b1);
    chk("n1_rise", rise[1], 1'b1);
    tick(1);
    chk("n1_rise_1cyc", rise[1], 1'b0);
    a_in[1] = 1'b0;
    tick(2);
    chk("n1_hold", y[1], 1'b1);
    tick(1);
    chk("n1_fall", fall[1], 1'b1);
    tick(2);

    // N=1: a one-cycle glitch passes as one rise then one fall.
    a_in[1] = 1'b1; tick(1);
    a_in[1] = 1'b0;
    tick(1);
    chk("glitch_y_early", y[1], 1'b0);
    tick(1);
    chk("glitch_rise", rise[1], 1'b1);
    chk("glitch_y", y[1], 1'b1);
    tick(1);
    chk("glitch_fall", fall[1], 1'b1);
    chk("glitch_rise_gone", rise[1], 1'b0);
    chk("glitch_y_low", y[1], 1'b0);
    chk("glitch_inv", inv[1], 1'b1);
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
